// File: rtl/incr_pkg.sv
// Shared types and default sizing for the incrementer arbiter slice.
package incr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 4;

endpackage

// File: rtl/incr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_req
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Scan candidates in priority order starting at the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = IDW'((int'(ptr) + i) % N_REQ);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/incr_arbiter.sv
// Round-robin sequencer that owns a single registered +1 datapath and returns
// each result tagged with the index of the requester it served.
module incr_arbiter
  import incr_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*DW-1:0]      req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DW-1:0]            rsp_data_o,
  output logic [$clog2(N_REQ)-1:0] rsp_id_o,
  output logic                     rsp_wrap_o,
  output logic                     busy_o
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N_REQ - 1);

  state_e         state_r;
  state_e         state_next_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] id_r;
  logic [DW-1:0]  operand_r;
  logic [DW-1:0]  result_r;
  logic           wrap_r;

  logic [N_REQ-1:0] grant_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             any_req_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid_i),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_req   (any_req_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: state_next_s = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, increment stage and pointer advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r     <= '0;
      id_r      <= '0;
      operand_r <= '0;
      result_r  <= '0;
      wrap_r    <= 1'b0;
    end else begin
      if (state_r == IDLE && any_req_s) begin
        operand_r <= req_data_i[int'(grant_idx_s)*DW +: DW];
        id_r      <= grant_idx_s;
      end
      if (state_r == CALC) begin
        result_r <= operand_r + 1'b1;
        wrap_r   <= (operand_r == {DW{1'b1}});
      end
      if (state_r == RESP && rsp_ready_i) begin
        ptr_r <= (id_r == ID_LAST) ? '0 : id_r + 1'b1;
      end
    end
  end

  // Ready is masked by reset so a held valid cannot see a grant while reset is asserted.
  assign req_ready_o = (state_r == IDLE && !rst_i) ? grant_s : '0;
  assign rsp_valid_o = (state_r == RESP);
  assign busy_o      = (state_r != IDLE);
  assign rsp_data_o  = result_r;
  assign rsp_id_o    = id_r;
  assign rsp_wrap_o  = wrap_r;

endmodule

// File: tb/tb_incr_arbiter.sv
// Randomised and directed bench for incr_arbiter with a transaction-level
// round-robin model feeding a scoreboard that a separate monitor drains.
module tb_incr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 4;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N*DW-1:0]    req_data;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_wrap;
  logic               busy;

  incr_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_wrap_o  (rsp_wrap),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            id;
    logic          wrap;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  bit            front_seen = 1'b0;
  logic [DW-1:0] q_op[N][$];
  bit            vld[N];
  logic [DW-1:0] dat[N];
  int            mptr  = 0;
  bit            mbusy = 1'b0;
  int            rdy_mode = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One bench cycle: present requests, then compare the grant with the model.
  task automatic step();
    int g;
    logic [DW-1:0] e;
    bit any;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (!vld[k] && q_op[k].size() > 0) begin
        vld[k] = 1'b1;
        dat[k] = q_op[k].pop_front();
      end
      req_valid[k]           = vld[k];
      req_data[k*DW +: DW]   = dat[k];
    end
    case (rdy_mode)
      1:       rsp_ready = 1'($urandom_range(0, 1));
      2:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
    #1;
    any = 1'b0;
    for (int k = 0; k < N; k++) if (vld[k]) any = 1'b1;
    if (mbusy || !any) begin
      chk("ready_zero", int'(req_ready), 0);
    end else begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        if (g < 0 && vld[(mptr + i) % N]) g = (mptr + i) % N;
      end
      chk("grant", int'(req_ready), 1 << g);
      e = dat[g] + 4'd1;
      sb.push_back('{data: e, id: g, wrap: (dat[g] == 4'hF), acc: cyc});
      mbusy  = 1'b1;
      mptr   = (g + 1) % N;
      vld[g] = 1'b0;
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every presented response with the scoreboard head.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id %0d data %0d expected no response", rsp_id, rsp_data);
        end else begin
          if (!front_seen) begin
            chk("latency", cyc, sb[0].acc + 2);
            front_seen = 1'b1;
          end
          chk("rsp_data", int'(rsp_data), int'(sb[0].data));
          chk("rsp_id",   int'(rsp_id),   sb[0].id);
          chk("rsp_wrap", int'(rsp_wrap), int'(sb[0].wrap));
          chk("busy_resp", int'(busy), 1);
          if (rsp_ready) begin
            void'(sb.pop_front());
            front_seen = 1'b0;
            mbusy      = 1'b0;
          end
        end
      end else if (sb.size() > 0 && !front_seen && cyc > sb[0].acc + 2) begin
        total++;
        bad++;
        $display("FAIL rsp_timeout: got no valid by cycle %0d expected at %0d", cyc, sb[0].acc + 2);
        void'(sb.pop_front());
        mbusy = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_data"},  int'(rsp_data),  0);
    chk({tag, "_rsp_id"},    int'(rsp_id),    0);
    chk({tag, "_rsp_wrap"},  int'(rsp_wrap),  0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic increment, then the all-ones wrap.
    q_op[0].push_back(4'hA);
    steps(4);
    q_op[1].push_back(4'hF);
    steps(4);

    // Every requester continuously valid with data k+1.
    for (int k = 0; k < N; k++) begin
      q_op[k].push_back(4'(k + 1));
      q_op[k].push_back(4'(k + 1));
    end
    steps(28);

    // Lone requester 2, then 0 and 2 together with the pointer at 3.
    q_op[2].push_back(4'h5);
    steps(4);
    q_op[0].push_back(4'h6);
    q_op[2].push_back(4'h7);
    steps(8);

    // Consumer stalls for several cycles while others are pending.
    rdy_mode = 2;
    q_op[3].push_back(4'h9);
    q_op[1].push_back(4'h3);
    steps(8);
    rdy_mode = 0;
    steps(8);

    // Asynchronous reset while the accepted transaction is in CALC.
    q_op[0].push_back(4'h7);
    steps(4);
    chk("pre_reset_sb", sb.size(), 0);
    q_op[0].push_back(4'h7);
    step();
    chk("reset_accept", sb.size(), 1);
    @(posedge clk);
    #1;
    chk("calc_busy", int'(busy), 1);
    vld[3] = 1'b1;
    dat[3] = 4'hC;
    req_valid[3]    = 1'b1;
    req_data[12 +: 4] = 4'hC;
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midcalc");
    sb.delete();
    front_seen = 1'b0;
    mbusy      = 1'b0;
    mptr       = 0;
    #1;
    rst = 1'b0;
    steps(5);

    // Randomised traffic with a random consumer.
    rdy_mode = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        if (q_op[k].size() < 3) q_op[k].push_back(4'($urandom));
      end
      step();
    end
    rdy_mode = 0;
    for (int c = 0; c < 80; c++) step();
    chk("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/incr_arbiter.md
Name: incr_arbiter

Overview:
- Shares one registered 4-bit incrementer datapath between N_REQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Each response returns the result tagged with the winning requester's index.
- Sits between client blocks and the shared increment stage. It is the sequencer and owner of that stage.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- DW, 4, data width of operand and result
- IDW, $clog2(N_REQ), width of requester index (derived, not overridable)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  N_REQ  per-requester request valid
- req_data_i  in  N_REQ*DW  per-requester operand; requester k at bits [k*DW +: DW]
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer accepts result
- rsp_data_o  out  DW  operand+1 modulo 2^DW
- rsp_id_o  out  IDW  index of requester served
- rsp_wrap_o  out  1  operand was all-ones (result wrapped to 0)
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - FSM=IDLE; rr pointer=0.
  - rsp_valid_o, rsp_data_o, rsp_id_o, rsp_wrap_o, busy_o = 0.
  - req_ready_o = 0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid_i bit is set, grant g = first set bit searching from ptr upward, wrapping at N_REQ-1 -> 0.
  - req_ready_o[g]=1 combinationally in the same cycle; all other ready bits 0.
  - Handshake completes that cycle: capture operand and g into internal regs; next state CALC.
  - No valid: stay in IDLE, req_ready_o=0.
- CALC (exactly 1 cycle):
  - result_q <= operand_q + 1, truncated to DW.
  - wrap_q <= (operand_q == all-ones).
  - Next state RESP.
- RESP:
  - rsp_valid_o=1; rsp_data_o, rsp_id_o, rsp_wrap_o held stable until handshake.
  - On rsp_valid_o && rsp_ready_i: ptr <= (g+1) mod N_REQ; next state IDLE.
- req_ready_o=0 in CALC and RESP. Requesters must hold valid and data until ready (AXI-style; no retraction assumed by the block).
- Latency: request accept to rsp_valid_o = 2 cycles. Minimum issue interval = 3 cycles (accept, calc, respond with ready=1).
- Boundary conditions:
  - Operand all-ones -> rsp_data_o=0, rsp_wrap_o=1.
  - ptr past the last active requester -> search wraps to index 0.
  - Only requester g' requesting -> granted regardless of ptr.
  - rsp_ready_i high outside RESP: ignored.
  - Request arriving while busy: waits; no loss, no reorder among its own transactions.
  - Reset mid-CALC or mid-RESP: transaction dropped, all outputs return to reset values immediately, ptr=0.
- rsp_valid_o is registered (FSM-state decode of flops); no combinational path from rsp_ready_i to rsp_valid_o.

Decomposition:
- incr_pkg: state enum typedef (IDLE/CALC/RESP), default DW/N_REQ constants.
- Sub-module rr_arbiter (N_REQ):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.
- incr_arbiter: FSM, ptr, operand/result registers.

Test Plan:
- Reset then requester 0 valid with data 4'hA -> req_ready_o=4'b0001 same cycle; 2 cycles later rsp_valid_o=1, rsp_data_o=4'hB, rsp_id_o=0, rsp_wrap_o=0.
- Requester 1 data 4'hF -> rsp_data_o=4'h0, rsp_wrap_o=1, rsp_id_o=1.
- All 4 requesters continuously valid (data 1,2,3,4), rsp_ready_i=1 -> ids served 0,1,2,3,0; results 2,3,4,5,2; accepts every 3 cycles.
- After serving id 3 (ptr=0), only requester 2 valid -> granted id 2; next grant with 0 and 2 valid -> id 0 (ptr=3 wraps).
- rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o/data/id stable; req_ready_o=0 throughout despite pending valids.
- rst_i pulsed asynchronously in CALC -> outputs zero without a clock edge; after release, pending requester 3 served with id 3 and correct result.
